emu_run_ctrl: RTL and testbench

// Emulator-side responder for the host/testbench time-control protocol: it serves the

---
 rtl/emu_ctrl_pkg.sv | 32 +++
 rtl/emu_dt_clamp.sv | 24 ++
 rtl/emu_run_ctrl.sv | 109 ++++++++++
 tb/tb_emu_run_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/emu_ctrl_pkg.sv
// rtl/emu_ctrl_pkg.sv - shared types, defaults and saturating add for the emulator run controller
package emu_ctrl_pkg;

  localparam int TIME_W_DEF     = 40;
  localparam int DT_W_DEF       = 24;
  localparam int RST_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    OP_WAIT_RST = 2'd0,
    OP_SLEEP    = 2'd1,
    OP_GET_TIME = 2'd2,
    OP_RSVD     = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_RST_HOLD = 2'd0,
    S_IDLE     = 2'd1,
    S_RUN      = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  // Unsigned a+b clamped to the largest value representable in w bits (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (sum > {1'b0, max_v}) ? max_v : sum[63:0];
  endfunction

endpackage

// File: rtl/emu_dt_clamp.sv
// rtl/emu_dt_clamp.sv - per-cycle timestep limit: min(dt_req, target - t)
module emu_dt_clamp #(
  parameter int TIME_W = 40,
  parameter int DT_W   = 24
) (
  input  logic [DT_W-1:0]   dt_req,
  input  logic [TIME_W-1:0] t_now,
  input  logic [TIME_W-1:0] t_target,
  output logic [DT_W-1:0]   dt_out
);

  localparam logic [TIME_W-1:0] DT_MAX_T = {{(TIME_W-DT_W){1'b0}}, {DT_W{1'b1}}};

  logic [TIME_W-1:0] remaining;
  logic [DT_W-1:0]   rem_dt;

  // A remaining distance wider than the timestep field is capped at the largest step.
  always_comb begin
    remaining = t_target - t_now;
    rem_dt    = (remaining > DT_MAX_T) ? {DT_W{1'b1}} : remaining[DT_W-1:0];
    dt_out    = (dt_req < rem_dt) ? dt_req : rem_dt;
  end

endmodule

// File: rtl/emu_run_ctrl.sv
// rtl/emu_run_ctrl.sv - emulator time-control responder: reset hold, sleep-until-target, get-time
module emu_run_ctrl
  import emu_ctrl_pkg::*;
#(
  parameter int TIME_W     = TIME_W_DEF,
  parameter int DT_W       = DT_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic              emu_clk,
  input  logic              emu_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [TIME_W-1:0] cmd_arg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TIME_W-1:0] rsp_time,
  input  logic [DT_W-1:0]   dt_req,
  output logic [DT_W-1:0]   dt_grant,
  output logic              model_rst,
  output logic              stall
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIME_W-1:0] t_q, t_d;
  logic [TIME_W-1:0] target_q, target_d;
  logic [TIME_W-1:0] sleep_target;
  logic [DT_W-1:0]   clamp_dt;

  emu_dt_clamp #(.TIME_W(TIME_W), .DT_W(DT_W)) u_clamp (
    .dt_req   (dt_req),
    .t_now    (t_q),
    .t_target (target_q),
    .dt_out   (clamp_dt)
  );

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q  <= S_RST_HOLD;
      cnt_q    <= CNT_W'(RST_CYCLES - 1);
      t_q      <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    t_d          = t_q;
    target_d     = target_q;
    sleep_target = TIME_W'(sat_add(64'(t_q), 64'(cmd_arg), TIME_W));
    case (state_q)
      S_RST_HOLD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_IDLE: begin
        if (cmd_valid) begin
          if (op_t'(cmd_op) == OP_SLEEP) begin
            target_d = sleep_target;
            // Zero duration or an already saturated clock has nothing to run.
            state_d  = (sleep_target == t_q) ? S_RESP : S_RUN;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RUN: begin
        t_d = t_q + TIME_W'(clamp_dt);
        if (t_d == target_q) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_RST_HOLD;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_time  = '0;
    dt_grant  = '0;
    model_rst = 1'b0;
    stall     = 1'b1;
    case (state_q)
      S_RST_HOLD: model_rst = 1'b1;
      S_IDLE:     cmd_ready = 1'b1;
      S_RUN: begin
        dt_grant = clamp_dt;
        stall    = (clamp_dt == '0);
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_time  = t_q;
      end
      default: model_rst = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_emu_run_ctrl.sv
// tb/tb_emu_run_ctrl.sv - self-checking bench for emu_run_ctrl
module tb_emu_run_ctrl;
  import emu_ctrl_pkg::*;

  localparam int TW = 32;
  localparam int DW = 24;
  localparam int RC = 16;
  localparam logic [63:0] TMAX  = 64'hFFFF_FFFF;
  localparam logic [63:0] DTMAX = 64'h00FF_FFFF;

  logic          emu_clk, emu_rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [TW-1:0] cmd_arg;
  logic          rsp_valid, rsp_ready;
  logic [TW-1:0] rsp_time;
  logic [DW-1:0] dt_req, dt_grant;
  logic          model_rst, stall;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] t_m;
  logic [63:0] gq[$];

  emu_run_ctrl #(.TIME_W(TW), .DT_W(DW), .RST_CYCLES(RC)) dut (
    .emu_clk(emu_clk), .emu_rst(emu_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_time(rsp_time),
    .dt_req(dt_req), .dt_grant(dt_grant), .model_rst(model_rst), .stall(stall)
  );

  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Hold reset three cycles, release, then check the reset-hold window edge by edge.
  task automatic do_reset();
    @(negedge emu_clk);
    emu_rst = 1'b1;
    repeat (3) @(posedge emu_clk);
    @(negedge emu_clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_time", rsp_time, 0);
    chk("rst_dt_grant", dt_grant, 0);
    chk("rst_model_rst", model_rst, 1);
    chk("rst_stall", stall, 1);
    emu_rst = 1'b0;
    for (int k = 1; k <= RC; k++) begin
      @(posedge emu_clk);
      @(negedge emu_clk);
      chk("hold_model_rst", model_rst, (k < RC));
      chk("hold_cmd_ready", cmd_ready, (k == RC));
      chk("hold_stall", stall, 1);
    end
    t_m = 0;
  endtask

  // Issue one command; the model tracks the remaining distance to the target.
  task automatic do_cmd(input logic [1:0] op, input logic [63:0] arg, input int dconst,
                        input int hold, output int lat, output logic [63:0] rt);
    logic [63:0] rem, exp_t, d, g;
    int guard;
    lat = 0;
    rt  = '0;
    gq.delete();
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge emu_clk);
      guard++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg[TW-1:0];
    if (op == OP_SLEEP) exp_t = (t_m + arg > TMAX) ? TMAX : t_m + arg;
    else                exp_t = t_m;
    rem = exp_t - t_m;
    @(posedge emu_clk);
    @(negedge emu_clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (lat < 4000) begin
      chk("rsp_valid", rsp_valid, (rem == 0));
      if (rsp_valid !== (rem == 0) || rem == 0) break;
      if (dconst < 0) d = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 40));
      else            d = 64'(dconst);
      dt_req = d[DW-1:0];
      #1;
      g = d;
      if (rem < g)   g = rem;
      if (DTMAX < g) g = DTMAX;
      chk("dt_grant", dt_grant, g);
      chk("stall_run", stall, (g == 0));
      gq.push_back(64'(dt_grant));
      rem = rem - g;
      t_m = t_m + g;
      @(negedge emu_clk);
      lat++;
    end
    if (lat >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no response after %0d cycles expected one", lat);
    end
    rt = 64'(rsp_time);
    chk("rsp_time", rsp_time, exp_t);
    chk("rsp_cmd_ready", cmd_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge emu_clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_time", rsp_time, exp_t);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge emu_clk);
    @(negedge emu_clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    t_m = exp_t;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] arg;
    int          d;
    logic [63:0] exp_time;
    int          exp_lat;
  } vec_t;

  vec_t tbl[7];
  int lat;
  logic [63:0] rt;

  initial begin
    emu_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = '0;
    rsp_ready = 1'b0;
    dt_req    = 24'd5;
    t_m       = 0;

    tbl[0] = '{OP_WAIT_RST, 64'd0,   10, 64'd0,   1};
    tbl[1] = '{OP_GET_TIME, 64'd0,   10, 64'd0,   1};
    tbl[2] = '{OP_SLEEP,    64'd100, 10, 64'd100, 11};
    tbl[3] = '{OP_SLEEP,    64'd25,  10, 64'd125, 4};
    tbl[4] = '{2'b11,       64'd55,  10, 64'd125, 1};
    tbl[5] = '{OP_SLEEP,    64'd0,   10, 64'd125, 1};
    tbl[6] = '{OP_SLEEP,    64'd7,   3,  64'd132, 4};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      do_cmd(tbl[i].op, tbl[i].arg, tbl[i].d, (i == 1) ? 2 : 0, lat, rt);
      chk("vec_time", rt, tbl[i].exp_time);
      chk("vec_lat", 64'(lat), 64'(tbl[i].exp_lat));
      if (i == 3) begin
        chk("grant_count", 64'(gq.size()), 3);
        if (gq.size() == 3) begin
          chk("grant0", gq[0], 10);
          chk("grant1", gq[1], 10);
          chk("grant2", gq[2], 5);
        end
      end
    end

    for (int i = 0; i < 25; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 64'($urandom_range(0, 300)), -1,
             $urandom_range(0, 2), lat, rt);
    end

    // Saturation: park near the top, overshoot, then a sleep must respond at once.
    do_cmd(OP_SLEEP, (TMAX - 4) - t_m, 32'hFF_FFFF, 0, lat, rt);
    chk("near_max_time", rt, TMAX - 4);
    do_cmd(OP_SLEEP, 64'd100, 10, 0, lat, rt);
    chk("sat_time", rt, TMAX);
    chk("sat_lat", 64'(lat), 2);
    do_cmd(OP_SLEEP, 64'd100, 10, 0, lat, rt);
    chk("sat_again_time", rt, TMAX);
    chk("sat_again_lat", 64'(lat), 1);

    // Reset asserted mid-run at t=40.
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = OP_SLEEP;
    cmd_arg   = 32'd100;
    dt_req    = 24'd10;
    @(posedge emu_clk);
    @(negedge emu_clk);
    cmd_valid = 1'b0;
    repeat (4) @(posedge emu_clk);
    @(negedge emu_clk);
    chk("midrun_stall", stall, 0);
    chk("midrun_grant", dt_grant, 10);
    emu_rst = 1'b1;
    @(posedge emu_clk);
    @(negedge emu_clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_stall", stall, 1);
    chk("midrst_model_rst", model_rst, 1);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_dt_grant", dt_grant, 0);
    do_reset();
    do_cmd(OP_WAIT_RST, 64'd0, 10, 3, lat, rt);
    chk("after_rst_wait_time", rt, 0);
    do_cmd(OP_GET_TIME, 64'd0, 10, 0, lat, rt);
    chk("after_rst_time", rt, 0);
    chk("after_rst_lat", 64'(lat), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
